// File: rtl/qspi_sram_responder.sv
// rtl/qspi_sram_responder.sv - QSPI/SQI serial SRAM responder with byte-wide internal array
// Device end of a 23LC1024-style link: command decode, quad read/write bursts, auto-increment.

module qspi_sram_responder #(
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int START_QUAD     = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic sram_cs_n,
  input  logic sram_sck,
  input  logic sram_sio0_i,
  input  logic sram_sio1_i,
  input  logic sram_sio2_i,
  input  logic sram_sio3_i,
  output logic sram_sio0_o,
  output logic sram_sio1_o,
  output logic sram_sio2_o,
  output logic sram_sio3_o,
  output logic sram_sio_oe,
  output logic quad_mode
);

  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  typedef enum logic [2:0] {CMD, ADDR, DUMMY, READ, WRITE, IGNORE} state_t;

  state_t                    state, state_d;
  logic                      sck_q;
  logic [2:0]                cnt;
  logic [19:0]               shift;
  logic [MEM_ADDR_WIDTH-1:0] addr;
  logic                      is_write;
  logic [7:0]                rd_byte;
  logic                      hi_next;
  logic [3:0]                sio_o;
  logic [7:0]                mem [0:DEPTH-1];

  logic       rise, fall, cmd_last, mem_we;
  logic [3:0] nib;
  logic [7:0] cmd_byte, wr_data;
  logic [23:0] addr_full;
  logic        unused_addr_hi;

  assign rise      = sram_sck & ~sck_q & ~sram_cs_n;
  assign fall      = ~sram_sck & sck_q & ~sram_cs_n;
  assign nib       = {sram_sio3_i, sram_sio2_i, sram_sio1_i, sram_sio0_i};
  assign cmd_last  = quad_mode ? (cnt == 3'd1) : (cnt == 3'd7);
  assign cmd_byte  = quad_mode ? {shift[3:0], nib} : {shift[6:0], sram_sio0_i};
  assign addr_full = {shift, nib};
  assign wr_data   = {shift[3:0], nib};
  assign mem_we    = ~sram_cs_n && (state == WRITE) && rise && (cnt == 3'd1);
  assign unused_addr_hi = ^addr_full;

  assign sram_sio0_o = sio_o[0];
  assign sram_sio1_o = sio_o[1];
  assign sram_sio2_o = sio_o[2];
  assign sram_sio3_o = sio_o[3];

  always_comb begin
    state_d = state;
    if (sram_cs_n) begin
      state_d = CMD;
    end else begin
      case (state)
        CMD:
          if (rise && cmd_last)
            state_d = (quad_mode && (cmd_byte == 8'h02 || cmd_byte == 8'h03)) ? ADDR : IGNORE;
        ADDR:
          if (rise && cnt == 3'd5) state_d = is_write ? WRITE : DUMMY;
        DUMMY:
          if (fall && cnt == 3'd2) state_d = READ;
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= CMD;
      sck_q       <= 1'b0;
      quad_mode   <= (START_QUAD != 0);
      sio_o       <= 4'h0;
      sram_sio_oe <= 1'b0;
      cnt         <= 3'd0;
      shift       <= 20'h0;
      addr        <= '0;
      is_write    <= 1'b0;
      rd_byte     <= 8'h0;
      hi_next     <= 1'b0;
    end else begin
      state <= state_d;
      sck_q <= sram_sck;
      if (sram_cs_n) begin
        cnt         <= 3'd0;
        sio_o       <= 4'h0;
        sram_sio_oe <= 1'b0;
      end else begin
        case (state)
          CMD:
            if (rise) begin
              shift <= quad_mode ? {shift[15:0], nib} : {shift[18:0], sram_sio0_i};
              cnt   <= cmd_last ? 3'd0 : cnt + 3'd1;
              if (cmd_last) begin
                is_write <= (cmd_byte == 8'h02);
                if (!quad_mode && cmd_byte == 8'h38) quad_mode <= 1'b1;
                if (quad_mode && cmd_byte == 8'hFF)  quad_mode <= 1'b0;
              end
            end
          ADDR:
            if (rise) begin
              shift <= {shift[15:0], nib};
              if (cnt == 3'd5) begin
                cnt  <= 3'd0;
                addr <= addr_full[MEM_ADDR_WIDTH-1:0];
              end else begin
                cnt <= cnt + 3'd1;
              end
            end
          DUMMY: begin
            if (rise && cnt < 3'd2) begin
              cnt <= cnt + 3'd1;
              if (cnt == 3'd1) begin
                rd_byte <= mem[addr];
                addr    <= addr + 1'b1;
              end
            end
            if (fall && cnt == 3'd2) begin
              sio_o       <= rd_byte[7:4];
              sram_sio_oe <= 1'b1;
              hi_next     <= 1'b0;
            end
          end
          READ: begin
            // hi_next marks that the low nibble is out, so the coming rise prefetches the next byte
            if (fall) begin
              sio_o   <= hi_next ? rd_byte[7:4] : rd_byte[3:0];
              hi_next <= ~hi_next;
            end
            if (rise && hi_next) begin
              rd_byte <= mem[addr];
              addr    <= addr + 1'b1;
            end
          end
          WRITE:
            if (rise) begin
              shift <= {shift[15:0], nib};
              if (cnt == 3'd1) begin
                cnt  <= 3'd0;
                addr <= addr + 1'b1;
              end else begin
                cnt <= 3'd1;
              end
            end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= wr_data;
  end

endmodule

// File: tb/tb_qspi_sram_responder.sv
// tb/tb_qspi_sram_responder.sv - scoreboard bench for qspi_sram_responder
// Driver pushes expected read nibbles; a monitor pops them on each sck rise where the DUT drives.

module tb_qspi_sram_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sram_cs_n = 1'b1;
  logic sram_sck = 1'b0;
  logic [3:0] sio_i = 4'h0;
  logic sram_sio0_o, sram_sio1_o, sram_sio2_o, sram_sio3_o;
  logic sram_sio_oe, quad_mode;

  int n_tests = 0;
  int n_fail = 0;
  int oe_cycles = 0;

  logic [3:0] exp_q [$];
  logic [7:0] wbuf [$];
  logic [7:0] model [int];

  always #5 clk = ~clk;

  qspi_sram_responder #(.MEM_ADDR_WIDTH(16), .START_QUAD(0)) dut (
    .clk(clk),
    .reset(reset),
    .sram_cs_n(sram_cs_n),
    .sram_sck(sram_sck),
    .sram_sio0_i(sio_i[0]),
    .sram_sio1_i(sio_i[1]),
    .sram_sio2_i(sio_i[2]),
    .sram_sio3_i(sio_i[3]),
    .sram_sio0_o(sram_sio0_o),
    .sram_sio1_o(sram_sio1_o),
    .sram_sio2_o(sram_sio2_o),
    .sram_sio3_o(sram_sio3_o),
    .sram_sio_oe(sram_sio_oe),
    .quad_mode(quad_mode)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (sram_sio_oe) oe_cycles++;

  // controller samples read data on sck rise
  always @(posedge sram_sck) begin
    if (sram_sio_oe) begin
      logic [3:0] got, want;
      got = {sram_sio3_o, sram_sio2_o, sram_sio1_o, sram_sio0_o};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read_nibble: got %0h expected none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL read_nibble: got %0h expected %0h", got, want);
        end
      end
    end
  end

  task automatic sck_cyc(input logic [3:0] d);
    sram_sck = 1'b0;
    sio_i = d;
    repeat (2) @(negedge clk);
    sram_sck = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic begin_frame();
    sram_cs_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_frame();
    sram_sck = 1'b0;
    repeat (2) @(negedge clk);
    sram_cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sck_cyc({3'b000, b[i]});
  endtask

  task automatic quad_byte(input logic [7:0] b);
    sck_cyc(b[7:4]);
    sck_cyc(b[3:0]);
  endtask

  task automatic quad_hdr(input logic [7:0] op, input logic [23:0] a);
    quad_byte(op);
    for (int i = 5; i >= 0; i--) sck_cyc(a[i*4 +: 4]);
  endtask

  task automatic quad_write(input logic [23:0] a);
    begin_frame();
    quad_hdr(8'h02, a);
    for (int i = 0; i < wbuf.size(); i++) begin
      quad_byte(wbuf[i]);
      model[(int'(a) + i) & 16'hFFFF] = wbuf[i];
    end
    end_frame();
  endtask

  task automatic push_exp(input logic [23:0] a, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = model[(int'(a) + i) & 16'hFFFF];
      exp_q.push_back(b[7:4]);
      exp_q.push_back(b[3:0]);
    end
  endtask

  task automatic quad_read(input logic [23:0] a, input int n);
    push_exp(a, n);
    begin_frame();
    quad_hdr(8'h03, a);
    sck_cyc(4'h0);
    sck_cyc(4'h0);
    check("oe_low_before_data", sram_sio_oe, 1'b0);
    for (int i = 0; i < 2 * n; i++) sck_cyc(4'h0);
    end_frame();
    check("read_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int o0;
    logic [23:0] base, ra;
    int len, off, rlen;

    repeat (3) @(negedge clk);
    check("reset_quad_mode", quad_mode, 1'b0);
    check("reset_oe", sram_sio_oe, 1'b0);
    check("reset_sio", {sram_sio3_o, sram_sio2_o, sram_sio1_o, sram_sio0_o}, 4'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // EQIO in SPI mode
    o0 = oe_cycles;
    begin_frame();
    spi_byte(8'h38);
    end_frame();
    check("eqio_quad_mode", quad_mode, 1'b1);
    check("eqio_no_oe", oe_cycles - o0, 0);

    // basic write then read
    wbuf = '{8'hA5, 8'h3C};
    quad_write(24'h000010);
    quad_read(24'h000010, 2);

    // wrap at top of array
    wbuf = '{8'h11, 8'h22};
    quad_write(24'h00FFFF);
    quad_read(24'h000000, 1);
    quad_read(24'h00FFFF, 1);

    // aborted burst: third nibble must be discarded
    wbuf = '{8'h5E};
    quad_write(24'h000021);
    begin_frame();
    quad_hdr(8'h02, 24'h000020);
    sck_cyc(4'h7);
    sck_cyc(4'h7);
    sck_cyc(4'h9);
    end_frame();
    model[16'h0020] = 8'h77;
    quad_read(24'h000020, 2);

    // unknown opcode ignored
    o0 = oe_cycles;
    begin_frame();
    quad_byte(8'h05);
    for (int i = 0; i < 16; i++) sck_cyc(4'hF);
    end_frame();
    check("unknown_op_no_oe", oe_cycles - o0, 0);
    quad_read(24'h000020, 2);

    // RSTQIO
    begin_frame();
    quad_byte(8'hFF);
    end_frame();
    check("rstqio_quad_mode", quad_mode, 1'b0);

    // reset pulse in the middle of a read
    begin_frame();
    spi_byte(8'h38);
    end_frame();
    check("eqio2_quad_mode", quad_mode, 1'b1);
    push_exp(24'h000010, 2);
    void'(exp_q.pop_back());
    begin_frame();
    quad_hdr(8'h03, 24'h000010);
    sck_cyc(4'h0);
    sck_cyc(4'h0);
    for (int i = 0; i < 3; i++) sck_cyc(4'h0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midreset_oe", sram_sio_oe, 1'b0);
    check("midreset_quad_mode", quad_mode, 1'b0);
    end_frame();
    check("midreset_drained", exp_q.size(), 0);
    exp_q.delete();
    begin_frame();
    spi_byte(8'h38);
    end_frame();
    quad_read(24'h000010, 2);

    // randomized bursts with junk in the upper address byte
    for (int it = 0; it < 15; it++) begin
      base = {8'($urandom), 16'($urandom)};
      if (it % 4 == 0) base[15:0] = 16'hFFFD;
      len = $urandom_range(1, 6);
      wbuf.delete();
      for (int i = 0; i < len; i++) wbuf.push_back(8'($urandom));
      quad_write(base);
      off = $urandom_range(0, len - 1);
      rlen = $urandom_range(1, len - off);
      ra = {8'($urandom), 16'((int'(base[15:0]) + off) & 16'hFFFF)};
      quad_read(ra, rlen);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qspi_sram_responder.md
Name: qspi_sram_responder

Overview:
- Synthesizable responder model of a 23LC1024-style serial SRAM: the device end of the QSPI link driven by the SoC's SRAM encoder.
- Lets the SoC run on FPGA targets with no external SRAM chips, and serves as the bench memory for RAM/ROM/VRAM encoder regression.
- Decodes the command stream, holds a byte-wide internal array, and answers quad (SQI) read/write bursts with sequential auto-increment.

Parameters:
- MEM_ADDR_WIDTH, 16, log2 of array depth in bytes; incoming 24-bit address is truncated to this width, so accesses wrap.
- START_QUAD, 0, quad-mode value after reset (1 = skip the EQIO step).

Ports:
- clk  input  1  system clock; all sram_* inputs are generated in this domain, so there are no synchronizers.
- reset  input  1  synchronous, active-low reset.
- sram_cs_n  input  1  chip select, active low.
- sram_sck  input  1  serial clock, mode 0; clk/2 or slower.
- sram_sio0_i  input  1  SIO0 from controller (SI in SPI mode).
- sram_sio1_i  input  1  SIO1 from controller.
- sram_sio2_i  input  1  SIO2 from controller.
- sram_sio3_i  input  1  SIO3 from controller.
- sram_sio0_o  output  1  SIO0 to controller.
- sram_sio1_o  output  1  SIO1 to controller.
- sram_sio2_o  output  1  SIO2 to controller.
- sram_sio3_o  output  1  SIO3 to controller.
- sram_sio_oe  output  1  responder drives the SIO lines.
- quad_mode  output  1  1 = SQI mode active.

Behaviour:
- **Edge detection:** sck_q registers sram_sck. A rise is sck & ~sck_q; a fall is ~sck & sck_q. Edges are ignored while cs_n = 1.
- **Reset (reset = 0):**
  - state = CMD; quad_mode = START_QUAD; sio_o = 0; sio_oe = 0; counters = 0.
  - Array contents are not cleared.
- **cs_n = 1 at any clk:**
  - state returns to CMD; sio_oe = 0 on the next clk; bit and nibble counters clear.
  - A partially received byte is discarded.
  - quad_mode is retained.
  - Deasserting cs_n mid-burst simply ends the transaction.
- **Receive sampling:** all data is sampled on sck rise.
  - SPI mode: 1 bit from sio0, MSB first.
  - Quad mode: 1 nibble {sio3, sio2, sio1, sio0}, high nibble first.
- **States:**
  - CMD: collect 8 bits (SPI) or 2 nibbles (quad), then decode.
    - SPI 0x38 (EQIO): quad_mode <= 1, then IGNORE.
    - Quad 0xFF (RSTQIO): quad_mode <= 0, then IGNORE.
    - Quad 0x02: go to ADDR, flag write.
    - Quad 0x03: go to ADDR, flag read.
    - Any other opcode: IGNORE.
  - ADDR: 6 nibbles, MSB first, form a 24-bit address; the low MEM_ADDR_WIDTH bits are kept. Next state is WRITE or DUMMY.
  - DUMMY (read only): 2 sck rises.
    - On the 2nd rise, load shift byte = mem[addr] and increment addr.
    - On the following sck fall, drive the high nibble and set sio_oe = 1; go to READ.
  - READ:
    - Each sck fall drives the next nibble.
    - After the low nibble is driven, the next fall drives the high nibble of mem[addr], prefetched on the intervening rise; addr is then incremented.
    - Output is registered: it changes 1 clk after fall detection and is stable across the next rise.
  - WRITE:
    - Each 2 nibbles form a byte.
    - On the 2nd nibble rise: mem[addr] <= byte and addr <= addr + 1 in the same clk.
  - IGNORE: sck is counted but no effect; exit only on cs_n = 1.
- **Address arithmetic:** addr increments modulo 2^MEM_ADDR_WIDTH, so 0xFFFF + 1 = 0x0000 at the default width.
- **Output enable:** sio_oe = 1 only in READ. During CMD, ADDR and DUMMY, sio_oe = 0 and the controller owns the bus.
- **Latency:**
  - Quad read: first data nibble is valid after 2 cmd + 6 addr + 2 dummy sck cycles.
  - Write: the byte is visible to a subsequent read 1 clk after its 2nd nibble rise.
- **Read-after-write:** write and read to the same address in separate cs_n frames must return the written data.
- **Unimplemented:** SPI-mode read/write, and the mode-register commands. These fall to IGNORE, and their sio outputs stay 0.

Test Plan:
- Reset with START_QUAD = 0; send SPI 0x38 then raise cs_n -> quad_mode = 1, sio_oe never asserted.
- Quad write 0x02, addr 0x000010, data 0xA5 0x3C, then quad read 0x03 addr 0x000010 + 2 dummy -> nibbles A, 5, 3, C returned; sio_oe rises only after the 2nd dummy fall.
- Write 0x11, 0x22 at addr 0x00FFFF (MEM_ADDR_WIDTH = 16) -> read 0x000000 returns 0x22, read 0x00FFFF returns 0x11.
- Write burst aborted by cs_n high after 3 nibbles at addr 0x20 (data 0x77, then 0x9 nibble) -> mem[0x20] = 0x77, mem[0x21] unchanged; next frame decodes a fresh command.
- Unknown quad opcode 0x05 followed by 16 sck cycles -> sio_oe stays 0, memory unchanged; quad 0xFF -> quad_mode = 0.
- reset = 0 asserted mid-read for 1 clk -> sio_oe = 0 and state = CMD on the next clk; previously written data is still readable after re-entering quad mode.
